rgb_pwm_seq: RTL and testbench
==============================

# rgb_pwm_seq

Colour-sequencing PWM generator for the iCE40 RGB LED path. It accepts 24-bit colour requests over a valid/ready handshake and produces the three PWM waveforms that drive the `SB_RGBA_DRV` RGB0PWM/RGB1PWM/RGB2PWM inputs. It runs from the `SB_HFOSC` clock. New colours take effect only at a PWM period boundary, so the LED never shows a partial period.

## Interface
Parameters:
- `PRESCALE`, default 188: clocks per PWM phase step. At 48 MHz this gives about 997 Hz per 256-step period. Legal range is 1..65535.

Ports:
- `int_osc`  in  1: system clock from `SB_HFOSC`; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `enable`  in  1: high = run the PWM; low = outputs forced low and counters held.
- `col_valid`  in  1: colour request valid.
- `col_ready`  out  1: block can accept a request.
- `col_data`  in  24: requested colour. [23:16] red duty, [15:8] green duty, [7:0] blue duty.
- `pwm_r`, `pwm_g`, `pwm_b`  out  1 each: registered PWM outputs to the RGB driver.
- `period_tick`  out  1: one-cycle pulse on the first cycle of each PWM period.
- `busy`  out  1: a request is pending, or a fade is in progress.

## Operation
- **Prescaler:** `pre_cnt` counts 0..PRESCALE-1. Each wrap of `pre_cnt` advances the 8-bit `phase`, which wraps 255→0.
- **Boundary:** the cycle where `pre_cnt==PRESCALE-1` and `phase==255`.
- **PWM output:** `pwm_x` is registered as `(phase < duty_x)`.
  - duty 0 → always low.
  - duty 255 → high for 255 of 256 steps.
  - Full-on is not representable, by design.
- **Request register:** one pending register plus a `pend` flag. `col_ready = ~pend`.
  - On `col_valid & col_ready`, load the pending register and set `pend`.
- **State machine, states IDLE / PENDING:**
  - IDLE → PENDING on accept.
  - PENDING → IDLE at the next boundary: copy the pending value into `duty_x`, clear `pend`.
- **Same-cycle accept and boundary:** a request accepted on a boundary cycle waits for the following boundary.
- **enable low:**
  - `pre_cnt` and `phase` are held at 0; outputs are low.
  - Every cycle counts as a boundary, so a pending request applies on the cycle after it is accepted.
- **enable rising:** the period restarts at phase 0.
- `busy = pend` (fade term added under Configuration).
- **Reset values:**
  - pwm_r/g/b = 0, period_tick = 0, busy = 0, col_ready = 1.
  - All duties 0, pre_cnt 0, phase 0, pend 0.
- **Reset mid-operation:** the request is dropped and all state returns to the reset values immediately.

## Timing
- **Handshake:** transfer happens on a cycle with `col_valid & col_ready`. `col_data` is sampled that cycle. The sender must hold valid and data until ready.
- **Apply latency:** the new duty is used from phase 0 of the period after the next boundary. `pwm_x` reflects it one clock after that phase-0 cycle (registered output).
- **Worst-case latency:** request to visible change is 256·PRESCALE + 2 clocks.
- **period_tick:** registered, high on the cycle `pwm_x` first shows phase 0, so it is aligned with the outputs.
- **Back-to-back requests:** the second request is stalled (`col_ready`=0) until the boundary clears `pend`.

## Configuration
- Macro `RGB_PWM_FADE_EN`.
- **Defined:**
  - The pending value loads a `target_x` register instead of `duty_x`.
  - At every boundary, each `duty_x` steps 1 toward `target_x`.
  - `busy = pend | (duty != target)` for any channel.
  - A new request retargets the fade; fading continues from the current duty. Example: 0→255 takes 255 periods.
- **Undefined:** no target registers; duties change in one step at the boundary as described above.

## Structure
- **Package `rgb_pwm_pkg`:**
  - `typedef struct packed {logic [7:0] r, g, b;} rgb_t`, matching the `col_data` packing.
  - `localparam PHASE_W = 8`.
  - `localparam DEFAULT_PRESCALE = 188`.
- **Sub-module `pwm_channel`**, instantiated three times. Each contains:
  - the duty register;
  - the target register and ±1 fade step, under the macro;
  - the registered compare.
- Top-level `rgb_pwm_seq` owns the prescaler, phase counter, handshake, state machine and `period_tick`.

## Test plan
- **Reset check.** Stimulus: PRESCALE=2, assert rst mid-period. Response: all outputs 0 and col_ready=1 on the same cycle; after release, first period_tick at clock 512.
- **Duty sweep.** Stimulus: request 0x80_40_00, then count high cycles per 512-clock period. Response: r=256, g=128, b=0. Repeat with 0xFF_FF_FF: 510 each.
- **Handshake stall.** Stimulus: two back-to-back valid requests. Response: the second sees col_ready=0 until the boundary; each colour is applied in consecutive periods.
- **Accept on boundary.** Stimulus: valid asserted exactly on a boundary cycle. Response: the colour is applied one full period later, not immediately.
- **enable low.** Stimulus: drop enable, send request 0x10_10_10. Response: outputs stay 0 and pend clears on the next cycle; on re-enable, high time is 32 clocks per period from phase 0.
- **Fade build (RGB_PWM_FADE_EN).**
  - Request 0x03_00_00 from 0. Response: red duty 1, 2, 3 over three boundaries; busy falls after the third.
  - Retarget mid-fade to 0. Response: duty steps back down.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM colour sequencer.
// Also used by the optional fade build (RGB_PWM_FADE_EN).
package rgb_pwm_pkg;

   localparam int PHASE_W          = 8;
   localparam int DEFAULT_PRESCALE = 188;

   // Same packing as col_data: red in the top byte, blue in the bottom byte.
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } seq_state_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: duty register, registered phase compare and,
// when RGB_PWM_FADE_EN is defined, a target register with a +/-1 fade step.
module pwm_channel
   import rgb_pwm_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               boundary,
   input  logic               apply,
   input  logic [PHASE_W-1:0] phase,
   input  logic [PHASE_W-1:0] new_duty,
   output logic               pwm,
   output logic               busy
);

   logic [PHASE_W-1:0] duty_r;

`ifdef RGB_PWM_FADE_EN
   logic [PHASE_W-1:0] target_r;
   logic [PHASE_W-1:0] goal_s;

   // Fade goal: a target arriving on this boundary already steers this step
   always_comb begin
      goal_s = target_r;
      if (apply) begin
         goal_s = new_duty;
      end else begin
         goal_s = target_r;
      end
   end

   // Target register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         target_r <= 8'd0;
      end else if (apply) begin
         target_r <= new_duty;
      end
   end

   // Duty walks one step per boundary toward the goal
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_r <= 8'd0;
      end else if (boundary) begin
         if (duty_r < goal_s) begin
            duty_r <= duty_r + 8'd1;
         end else if (duty_r > goal_s) begin
            duty_r <= duty_r - 8'd1;
         end
      end
   end

   assign busy = (duty_r != target_r);
`else
   // Duty register, replaced in one step at a boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_r <= 8'd0;
      end else if (apply && boundary) begin
         duty_r <= new_duty;
      end
   end

   assign busy = 1'b0;
`endif

   // Registered compare; duty 255 still leaves one low step per period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm <= 1'b0;
      end else begin
         pwm <= enable & (phase < duty_r);
      end
   end

endmodule

// File: rtl/rgb_pwm_seq.sv
// Colour-sequencing PWM generator for the iCE40 RGB driver; colours change
// only at period boundaries. Optional fade: define RGB_PWM_FADE_EN.
module rgb_pwm_seq
   import rgb_pwm_pkg::*;
#(
   parameter int PRESCALE = DEFAULT_PRESCALE
) (
   input  logic        int_osc,
   input  logic        rst,
   input  logic        enable,
   input  logic        col_valid,
   output logic        col_ready,
   input  logic [23:0] col_data,
   output logic        pwm_r,
   output logic        pwm_g,
   output logic        pwm_b,
   output logic        period_tick,
   output logic        busy
);

   localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

   logic [15:0]        pre_cnt_r;
   logic [PHASE_W-1:0] phase_r;
   logic               wrap_r;
   logic               tick_r;
   logic               pre_last_s;
   logic               boundary_s;
   logic               accept_s;
   logic               apply_s;
   logic               pend_s;
   seq_state_e         state_r;
   seq_state_e         state_s;
   rgb_t               col_s;
   rgb_t               pend_col_r;
   logic [2:0]         ch_busy_s;

   assign col_s      = col_data;
   assign pre_last_s = (pre_cnt_r == PRE_LAST);
   assign pend_s     = (state_r == PENDING);
   assign accept_s   = col_valid & ~pend_s;

   // With the PWM stopped every cycle is a boundary so requests land at once
   always_comb begin
      boundary_s = 1'b1;
      if (enable) begin
         boundary_s = pre_last_s & (phase_r == 8'hFF);
      end else begin
         boundary_s = 1'b1;
      end
   end

   // Prescaler and phase counter, parked at zero while disabled
   always_ff @(posedge int_osc or posedge rst) begin
      if (rst) begin
         pre_cnt_r <= 16'd0;
         phase_r   <= 8'd0;
      end else if (!enable) begin
         pre_cnt_r <= 16'd0;
         phase_r   <= 8'd0;
      end else if (pre_last_s) begin
         pre_cnt_r <= 16'd0;
         phase_r   <= phase_r + 8'd1;
      end else begin
         pre_cnt_r <= pre_cnt_r + 16'd1;
      end
   end

   // Period tick trails the phase-0 cycle by one clock to line up with pwm_x
   always_ff @(posedge int_osc or posedge rst) begin
      if (rst) begin
         wrap_r <= 1'b0;
         tick_r <= 1'b0;
      end else begin
         wrap_r <= boundary_s;
         tick_r <= enable & wrap_r;
      end
   end

   // Request state register
   always_ff @(posedge int_osc or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state; an accept on a boundary cycle waits for the next boundary
   always_comb begin
      state_s = state_r;
      apply_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = PENDING;
            end else begin
               state_s = IDLE;
            end
         end
         PENDING: begin
            if (boundary_s) begin
               state_s = IDLE;
               apply_s = 1'b1;
            end else begin
               state_s = PENDING;
            end
         end
         default: begin
            state_s = IDLE;
            apply_s = 1'b0;
         end
      endcase
   end

   // Pending colour register
   always_ff @(posedge int_osc or posedge rst) begin
      if (rst) begin
         pend_col_r <= '0;
      end else if (accept_s) begin
         pend_col_r <= col_s;
      end
   end

   pwm_channel u_ch_r (
      .clk      (int_osc),
      .rst      (rst),
      .enable   (enable),
      .boundary (boundary_s),
      .apply    (apply_s),
      .phase    (phase_r),
      .new_duty (pend_col_r.r),
      .pwm      (pwm_r),
      .busy     (ch_busy_s[2])
   );

   pwm_channel u_ch_g (
      .clk      (int_osc),
      .rst      (rst),
      .enable   (enable),
      .boundary (boundary_s),
      .apply    (apply_s),
      .phase    (phase_r),
      .new_duty (pend_col_r.g),
      .pwm      (pwm_g),
      .busy     (ch_busy_s[1])
   );

   pwm_channel u_ch_b (
      .clk      (int_osc),
      .rst      (rst),
      .enable   (enable),
      .boundary (boundary_s),
      .apply    (apply_s),
      .phase    (phase_r),
      .new_duty (pend_col_r.b),
      .pwm      (pwm_b),
      .busy     (ch_busy_s[0])
   );

   assign col_ready   = ~pend_s;
   assign busy        = pend_s | (|ch_busy_s);
   assign period_tick = tick_r;

endmodule

// File: tb/tb_rgb_pwm_seq.sv
// Directed bench for rgb_pwm_seq with PRESCALE=2 (512-clock periods).
module tb_rgb_pwm_seq;

   localparam int P = 2;

   logic        int_osc = 1'b0;
   logic        rst;
   logic        enable;
   logic        col_valid;
   logic        col_ready;
   logic [23:0] col_data;
   logic        pwm_r;
   logic        pwm_g;
   logic        pwm_b;
   logic        period_tick;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int n;

   rgb_pwm_seq #(.PRESCALE(P)) dut (
      .int_osc     (int_osc),
      .rst         (rst),
      .enable      (enable),
      .col_valid   (col_valid),
      .col_ready   (col_ready),
      .col_data    (col_data),
      .pwm_r       (pwm_r),
      .pwm_g       (pwm_g),
      .pwm_b       (pwm_b),
      .period_tick (period_tick),
      .busy        (busy)
   );

   always #5 int_osc = ~int_osc;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge int_osc);
      #1;
   endtask

   task automatic wait_tick(input int limit, output int cnt);
      cnt = 0;
      while (!period_tick && cnt < limit) begin
         step();
         cnt++;
      end
   endtask

   task automatic send(input string tag, input logic [23:0] c);
      check_eq({tag, "_ready"}, col_ready, 1);
      col_valid = 1'b1;
      col_data  = c;
      step();
      col_valid = 1'b0;
   endtask

   // Counts high clocks per channel over one period starting at its tick
   task automatic measure(input string tag, input int er, input int eg, input int eb);
      int w;
      int cr;
      int cg;
      int cb;
      wait_tick(1100, w);
      check_eq({tag, "_tick"}, period_tick, 1);
      cr = 0;
      cg = 0;
      cb = 0;
      for (int i = 0; i < 512; i++) begin
         cr += int'(pwm_r);
         cg += int'(pwm_g);
         cb += int'(pwm_b);
         step();
      end
      check_eq({tag, "_r"}, cr, er);
      check_eq({tag, "_g"}, cg, eg);
      check_eq({tag, "_b"}, cb, eb);
   endtask

   initial begin
      rst       = 1'b1;
      enable    = 1'b1;
      col_valid = 1'b0;
      col_data  = 24'h0;
      repeat (3) step();
      check_eq("rst_pwm", {pwm_r, pwm_g, pwm_b}, 0);
      check_eq("rst_tick", period_tick, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_ready", col_ready, 1);
      rst = 1'b0;
      wait_tick(600, n);
      check_eq("first_tick", n, 513);

`ifdef RGB_PWM_FADE_EN
      send("fade_up", 24'h030000);
      check_eq("fade_busy0", busy, 1);
      measure("fade1", 2, 0, 0);
      measure("fade2", 4, 0, 0);
      check_eq("fade_busy_done", busy, 0);
      measure("fade3", 6, 0, 0);
      send("fade_dn", 24'h000000);
      check_eq("fade_busy1", busy, 1);
      measure("fade4", 4, 0, 0);
      measure("fade5", 2, 0, 0);
`else
      // Duty sweep
      send("sw1", 24'h804000);
      check_eq("sw1_busy", busy, 1);
      check_eq("sw1_stall", col_ready, 0);
      measure("sweep1", 256, 128, 0);
      check_eq("sw1_idle", busy, 0);
      send("sw2", 24'hFFFFFF);
      measure("sweep2", 510, 510, 510);

      // Back-to-back requests
      send("bb_a", 24'h102030);
      col_valid = 1'b1;
      col_data  = 24'h405060;
      n = 0;
      while (!col_ready && n < 1100) begin
         step();
         n++;
      end
      check_eq("stall_cycles", n, 510);
      step();
      col_valid = 1'b0;
      measure("stall_a", 32, 64, 96);
      measure("stall_b", 128, 160, 192);

      // Accept exactly on a boundary cycle
      repeat (510) step();
      send("bnd", 24'h0800FF);
      check_eq("bnd_busy", busy, 1);
      measure("bnd_old", 128, 160, 192);
      measure("bnd_new", 16, 0, 510);

      // Disabled operation and restart
      enable = 1'b0;
      step();
      check_eq("dis_pwm0", {pwm_r, pwm_g, pwm_b}, 0);
      send("dis", 24'h101010);
      check_eq("dis_busy", busy, 1);
      step();
      check_eq("dis_pend_clr", busy, 0);
      check_eq("dis_ready", col_ready, 1);
      repeat (3) step();
      check_eq("dis_pwm1", {pwm_r, pwm_g, pwm_b}, 0);
      check_eq("dis_tick", period_tick, 0);
      enable = 1'b1;
      step();
      check_eq("en_tick", period_tick, 1);
      measure("en", 32, 32, 32);

      // Reset in the middle of a period with a request pending
      send("mid", 24'h808080);
      check_eq("mid_pwm_hi", pwm_r, 1);
      check_eq("mid_busy", busy, 1);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_pwm", {pwm_r, pwm_g, pwm_b}, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_ready", col_ready, 1);
      step();
      step();
      rst = 1'b0;
      wait_tick(600, n);
      check_eq("mid_first_tick", n, 513);
      measure("post_rst", 0, 0, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
